// File: rtl/video_pattern_gen.sv
// Pixel-domain colour stage: two-stage pipeline turning pixel coordinates and
// timing strobes into a registered 24-bit RGB test pattern with matched strobes.
module video_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int BAR_W      = 80,
    parameter int CHECK_LOG2 = 5
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        next_pattern,
    output logic [23:0] rgb,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [1:0]  pattern,
    output logic [7:0]  frame_count
);
    localparam int NBARS = H_ACTIVE / BAR_W;

    // Stage 1
    logic [9:0] x1_q, y1_q;
    logic       de1_q, hs1_q, vs1_q;
    logic [1:0] pat1_q;
    logic [7:0] fc1_q;

    // Stage 2
    logic [23:0] rgb_q, rgb_d;
    logic        de2_q, hs2_q, vs2_q;

    // Frame / pattern state
    logic [1:0] pattern_q, pattern_d;
    logic [7:0] fc_q, fc_d;
    logic       pending_q, pending_d;
    logic       frame_edge;

    // vs1_q doubles as the delayed copy used for rising-edge detection.
    assign frame_edge = vsync_in & ~vs1_q;

    always_comb begin
        pattern_d = pattern_q;
        fc_d      = fc_q;
        pending_d = pending_q | next_pattern;
        if (frame_edge) begin
            fc_d      = fc_q + 8'd1;
            pending_d = 1'b0;
            if (pending_q || next_pattern)
                pattern_d = pattern_q + 2'd1;
        end
    end

    logic [2:0] bar_idx;
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < NBARS; k++)
            if (int'(x1_q) >= k * BAR_W) bar_idx = 3'(k);
    end

    always_comb begin
        rgb_d = 24'h000000;
        if (de1_q) begin
            case (pat1_q)
                2'd0: begin
                    case (bar_idx)
                        3'd0:    rgb_d = 24'hffffff;
                        3'd1:    rgb_d = 24'hffff00;
                        3'd2:    rgb_d = 24'h00ffff;
                        3'd3:    rgb_d = 24'h00ff00;
                        3'd4:    rgb_d = 24'hff00ff;
                        3'd5:    rgb_d = 24'hff0000;
                        3'd6:    rgb_d = 24'h0000ff;
                        default: rgb_d = 24'h000000;
                    endcase
                end
                2'd1:    rgb_d = (x1_q[CHECK_LOG2] ^ y1_q[CHECK_LOG2]) ? 24'hffffff : 24'h000000;
                2'd2:    rgb_d = {3{x1_q[9:2]}};
                default: rgb_d = (x1_q[7:0] == fc1_q) ? 24'hffffff : 24'h0000ff;
            endcase
        end
    end

    // Only one bit of the row feeds the colour math.
    logic unused_y;
    assign unused_y = ^y1_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            x1_q      <= '0;
            y1_q      <= '0;
            de1_q     <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            pat1_q    <= '0;
            fc1_q     <= '0;
            rgb_q     <= '0;
            de2_q     <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            pattern_q <= '0;
            fc_q      <= '0;
            pending_q <= 1'b0;
        end else begin
            x1_q      <= pix_x;
            y1_q      <= pix_y;
            de1_q     <= de_in;
            hs1_q     <= hsync_in;
            vs1_q     <= vsync_in;
            pat1_q    <= pattern_q;
            fc1_q     <= fc_q;
            rgb_q     <= rgb_d;
            de2_q     <= de1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            pattern_q <= pattern_d;
            fc_q      <= fc_d;
            pending_q <= pending_d;
        end
    end

    assign rgb         = rgb_q;
    assign de_out      = de2_q;
    assign hsync_out   = hs2_q;
    assign vsync_out   = vs2_q;
    assign pattern     = pattern_q;
    assign frame_count = fc_q;
endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
Pixel-clock-domain colour stage that sits directly downstream of the pixel cursor / video timing generator and upstream of the ADV7513 data pins. It consumes the pixel coordinate, data-enable and sync strobes, and produces a registered 24-bit RGB pixel with the timing strobes delayed to match. It offers four selectable test patterns, stepped by a pulse request at frame boundaries.

Parameters:
H_ACTIVE, 640, active pixels per line
BAR_W, 80, colour-bar width in pixels; H_ACTIVE = 8*BAR_W
CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels

Ports:
clk_in  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
pix_x  input  10  current pixel column
pix_y  input  10  current pixel row
de_in  input  1  data enable, high in active area
hsync_in  input  1  horizontal sync, active-high
vsync_in  input  1  vertical sync, active-high
next_pattern  input  1  single-cycle request to advance pattern
rgb  output  24  pixel data {R[7:0],G[7:0],B[7:0]}
de_out  output  1  de_in delayed 2 cycles
hsync_out  output  1  hsync_in delayed 2 cycles
vsync_out  output  1  vsync_in delayed 2 cycles
pattern  output  2  pattern currently displayed
frame_count  output  8  frames since reset, wraps

Behaviour:
- Reset (async assert, sync release): rgb=0, de_out=hsync_out=vsync_out=0, pattern=0, frame_count=0, pending=0, all pipeline registers 0.
- Pipeline: exactly 2 clk_in cycles from inputs to outputs for rgb, de_out, hsync_out and vsync_out. Stage 1 registers pix_x, pix_y, de, hsync and vsync. Stage 2 registers the computed colour and the strobes. No bubbles and no stall.
- Frame edge: vsync_in rising edge, detected from a registered copy of vsync_in. On each edge: frame_count += 1 (wraps 255 -> 0).
- Pattern select:
  - next_pattern high sets pending.
  - At a frame edge with pending=1, or with next_pattern=1 in that same cycle: pattern <= pattern+1 (wraps 3 -> 0) and pending clears.
  - Multiple requests within one frame produce a single advance.
  - pattern never changes mid-frame.
- Colour (computed from stage-1 values; pattern and frame_count as sampled in stage 1):
  - 0 bars: idx = number of BAR_W boundaries at or below pix_x, clamped to 7, implemented as a compare chain with no divider. idx 0..7 gives ffffff, ffff00, 00ffff, 00ff00, ff00ff, ff0000, 0000ff, 000000.
  - 1 checker: pix_x[CHECK_LOG2]^pix_y[CHECK_LOG2] = 1 gives ffffff, otherwise 000000.
  - 2 gradient: R=G=B=pix_x[9:2].
  - 3 moving line: pix_x[7:0]==frame_count gives ffffff, otherwise 0000ff.
- Blanking: if stage-1 de=0 then rgb=0, regardless of pattern.
- Coordinates outside the active area with de high are not expected. Behaviour is still defined by the formulas above: bars clamp to black, gradient wraps.
- Reset mid-frame: all outputs drop to 0 immediately. pattern and frame_count restart at 0. The first vsync edge after release increments frame_count to 1.

Test Plan:
- Reset, then drive de_in=1, pix_x=0 then 85 then 639, pattern 0 -> rgb ffffff, ffff00, 000000, each appearing 2 cycles after its input.
- Toggle hsync_in/vsync_in/de_in with a pseudo-random pattern -> outputs match the inputs delayed exactly 2 cycles; rgb=0 whenever de_out=0.
- Pulse next_pattern 3 times mid-frame, then 1 vsync rising edge -> pattern goes 0 -> 1 only at the edge. With pattern 1: pix_x=32,pix_y=0 -> ffffff; pix_x=32,pix_y=32 -> 000000.
- next_pattern coincident with the vsync rising edge -> advance at that edge; pending=0 afterwards. Repeat 4 frames -> pattern wraps 3 -> 0.
- 256 vsync edges -> frame_count returns to 0. With pattern 3 and frame_count=10: pix_x=10 -> ffffff; pix_x=266 -> ffffff; pix_x=11 -> 0000ff.
- Assert reset_n low mid-line with pattern=2 and frame_count=5 -> all outputs 0 asynchronously. After release: pattern=0 and frame_count=0; pattern 2 with pix_x=400 (after re-selection) -> rgb 646464.
